// File: rtl/integral_pkg.sv
// Shared defaults and the clamp/wrap adder used by the integral row engine.
package integral_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int SUM_W_DEF = 20;

  // Operands are zero-extended into 64 bits; width must stay below 64.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned  width,
                                          input logic         sat);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << width) - 65'd1;
    if (sat && (sum > lim)) return lim[63:0];
    return sum[63:0] & lim[63:0];
  endfunction

endpackage

// File: rtl/integral_line_delay.sv
// Circular one-line delay of integral values with a runtime wrap width.
// Combinational read-before-write; pointer, pixel count and fill flag restart on sof.
module integral_line_delay #(
  parameter int SUM_W       = 20,
  parameter int MAX_FRAME_W = 640,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              sof,
  input  logic [ADDR_W:0]   cfg_width,
  input  logic [SUM_W-1:0]  wr_data,
  output logic [SUM_W-1:0]  rd_data,
  output logic              fill
);

  localparam logic [ADDR_W:0] MAXW = (ADDR_W+1)'(MAX_FRAME_W);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

  logic [SUM_W-1:0]  mem [MAX_FRAME_W];
  logic [ADDR_W-1:0] wr_ptr, ptr_cur, ptr_next;
  logic [ADDR_W:0]   width, width_cur, count, count_cur;
  logic              fill_cur;

  // An sof pixel sees the freshly latched width and a restarted line.
  always_comb begin
    width_cur = width;
    ptr_cur   = wr_ptr;
    count_cur = count;
    fill_cur  = fill;
    if (sof) begin
      width_cur = ((cfg_width == '0) || (cfg_width > MAXW)) ? MAXW : cfg_width;
      ptr_cur   = '0;
      count_cur = '0;
      fill_cur  = 1'b0;
    end
    ptr_next = ((ADDR_W+1)'(ptr_cur) == (width_cur - ONE)) ? '0 : ptr_cur + ADDR_W'(1);
    rd_data  = fill_cur ? mem[ptr_cur] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
      width  <= MAXW;
      fill   <= 1'b0;
    end else if (wr_en) begin
      wr_ptr <= ptr_next;
      width  <= width_cur;
      count  <= fill_cur ? count_cur : count_cur + ONE;
      fill   <= fill_cur | ((count_cur + ONE) == width_cur);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr_cur] <= wr_data;
  end

endmodule

// File: rtl/integral_row_window.sv
// Streaming integral-image row engine: one pixel per handshake, latency 1, single output stage.
// Exposes I(x,y) and the last WINDOW_W integral values of the current line.
module integral_row_window
  import integral_pkg::*;
#(
  parameter int PIX_W       = PIX_W_DEF,
  parameter int SUM_W       = SUM_W_DEF,
  parameter int MAX_FRAME_W = 640,
  parameter int ADDR_W      = 10,
  parameter int WINDOW_W    = 3,
  parameter int SATURATE    = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_W:0]           cfg_frame_width,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PIX_W-1:0]          in_pixel,
  input  logic                      in_sol,
  input  logic                      in_sof,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SUM_W-1:0]          o_integral,
  output logic [WINDOW_W*SUM_W-1:0] o_window,
  output logic                      o_fill
);

  localparam logic SAT = (SATURATE != 0);

  logic             accept, line_start;
  logic [SUM_W-1:0] row_sum, rs, above, integral;
  logic [SUM_W-1:0] taps [WINDOW_W];

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign line_start = in_sol || in_sof;

  always_comb begin
    rs       = SUM_W'(sat_add(64'(line_start ? '0 : row_sum), 64'(in_pixel), SUM_W, SAT));
    integral = SUM_W'(sat_add(64'(above), 64'(rs), SUM_W, SAT));
  end

  integral_line_delay #(
    .SUM_W       (SUM_W),
    .MAX_FRAME_W (MAX_FRAME_W),
    .ADDR_W      (ADDR_W)
  ) u_line_delay (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (accept),
    .sof       (in_sof),
    .cfg_width (cfg_frame_width),
    .wr_data   (integral),
    .rd_data   (above),
    .fill      (o_fill)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      o_integral <= '0;
      row_sum    <= '0;
      for (int k = 0; k < WINDOW_W; k++) taps[k] <= '0;
    end else begin
      if (accept) begin
        out_valid  <= 1'b1;
        o_integral <= integral;
        row_sum    <= rs;
        taps[0]    <= integral;
        // Older taps clear at a line start so the window never spans lines.
        for (int k = 1; k < WINDOW_W; k++) taps[k] <= line_start ? '0 : taps[k-1];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    o_window = '0;
    for (int k = 0; k < WINDOW_W; k++) o_window[k*SUM_W +: SUM_W] = taps[k];
  end

endmodule

// File: tb/tb_integral_row_window.sv
// Directed bench: default instance plus two 8-bit instances (clamp and wrap).
module tb_integral_row_window;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] cfg_frame_width = 11'd4;
  logic        in_valid = 1'b0, in_sol = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
  logic [7:0]  in_pixel = '0;
  logic        in_ready, out_valid, o_fill;
  logic [19:0] o_integral;
  logic [59:0] o_window;

  logic [10:0] s_cfg = 11'd2;
  logic        s_valid = 1'b0, s_sol = 1'b0, s_sof = 1'b0;
  logic [7:0]  s_pixel = '0;
  logic        c_ready, c_valid, c_fill, w_ready, w_valid, w_fill;
  logic [7:0]  c_integral, w_integral;
  logic [23:0] c_window, w_window;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  integral_row_window dut (
    .clk(clk), .reset(reset), .cfg_frame_width(cfg_frame_width),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .in_sol(in_sol), .in_sof(in_sof), .out_valid(out_valid), .out_ready(out_ready),
    .o_integral(o_integral), .o_window(o_window), .o_fill(o_fill)
  );

  integral_row_window #(.SUM_W(8), .SATURATE(1)) dut_clamp (
    .clk(clk), .reset(reset), .cfg_frame_width(s_cfg),
    .in_valid(s_valid), .in_ready(c_ready), .in_pixel(s_pixel),
    .in_sol(s_sol), .in_sof(s_sof), .out_valid(c_valid), .out_ready(1'b1),
    .o_integral(c_integral), .o_window(c_window), .o_fill(c_fill)
  );

  integral_row_window #(.SUM_W(8), .SATURATE(0)) dut_wrap (
    .clk(clk), .reset(reset), .cfg_frame_width(s_cfg),
    .in_valid(s_valid), .in_ready(w_ready), .in_pixel(s_pixel),
    .in_sol(s_sol), .in_sof(s_sof), .out_valid(w_valid), .out_ready(1'b1),
    .o_integral(w_integral), .o_window(w_window), .o_fill(w_fill)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] p, input logic sol, input logic sof);
    int n;
    in_pixel = p; in_sol = sol; in_sof = sof; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      tests++; failed++;
      $error("FAIL ready_timeout observed=0 expected=1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sol = 1'b0; in_sof = 1'b0;
  endtask

  task automatic push8(input logic [7:0] p, input logic sol, input logic sof);
    s_pixel = p; s_sol = sol; s_sof = sof; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_sol = 1'b0; s_sof = 1'b0;
  endtask

  // Width-4 frame of all-ones pixels, two lines.
  task automatic run_basic(input string pfx);
    cfg_frame_width = 11'd4;
    push(8'd1, 1'b1, 1'b1); chk({pfx, "_l1p1"}, o_integral, 1); chk({pfx, "_fill_p1"}, o_fill, 0);
    push(8'd1, 1'b0, 1'b0); chk({pfx, "_l1p2"}, o_integral, 2);
    push(8'd1, 1'b0, 1'b0); chk({pfx, "_l1p3"}, o_integral, 3); chk({pfx, "_fill_p3"}, o_fill, 0);
    chk({pfx, "_win0_l1p3"}, o_window[19:0], 3);
    chk({pfx, "_win1_l1p3"}, o_window[39:20], 2);
    chk({pfx, "_win2_l1p3"}, o_window[59:40], 1);
    push(8'd1, 1'b0, 1'b0); chk({pfx, "_l1p4"}, o_integral, 4); chk({pfx, "_fill_p4"}, o_fill, 1);
    push(8'd1, 1'b1, 1'b0); chk({pfx, "_l2p1"}, o_integral, 2);
    chk({pfx, "_win0_l2p1"}, o_window[19:0], 2);
    chk({pfx, "_win1_l2p1"}, o_window[39:20], 0);
    chk({pfx, "_win2_l2p1"}, o_window[59:40], 0);
    push(8'd1, 1'b0, 1'b0); chk({pfx, "_l2p2"}, o_integral, 4);
    push(8'd1, 1'b0, 1'b0); chk({pfx, "_l2p3"}, o_integral, 6);
    push(8'd1, 1'b0, 1'b0); chk({pfx, "_l2p4"}, o_integral, 8);
  endtask

  initial begin
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_integral", o_integral, 0);
    chk("rst_window", o_window, 0);
    chk("rst_fill", o_fill, 0);
    chk("rst_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_basic("s1");

    // Clamp vs wrap on 8-bit sums, width 2, all pixels 200.
    push8(8'd200, 1'b1, 1'b1);
    chk("sat_l1p1", c_integral, 200); chk("wrap_l1p1", w_integral, 200);
    push8(8'd200, 1'b0, 1'b0);
    chk("sat_l1p2", c_integral, 255); chk("wrap_l1p2", w_integral, 144);
    chk("sat_fill", c_fill, 1); chk("sat_valid", c_valid, 1);
    push8(8'd200, 1'b1, 1'b0);
    chk("sat_l2p1", c_integral, 255); chk("wrap_l2p1", w_integral, 144);
    push8(8'd200, 1'b0, 1'b0);
    chk("sat_l2p2", c_integral, 255); chk("wrap_l2p2", w_integral, 32);

    // Width change mid-frame is ignored until the next sof.
    cfg_frame_width = 11'd4;
    push(8'd1, 1'b1, 1'b1); chk("cfg_p1", o_integral, 1);
    cfg_frame_width = 11'd3;
    push(8'd1, 1'b0, 1'b0); chk("cfg_p2", o_integral, 2);
    push(8'd1, 1'b0, 1'b0); chk("cfg_p3", o_integral, 3); chk("cfg_fill_p3", o_fill, 0);
    push(8'd1, 1'b0, 1'b0); chk("cfg_p4", o_integral, 4); chk("cfg_fill_p4", o_fill, 1);
    push(8'd1, 1'b1, 1'b0); chk("cfg_l2p1", o_integral, 2);
    push(8'd1, 1'b1, 1'b1); chk("w3_p1", o_integral, 1); chk("w3_fill_p1", o_fill, 0);
    push(8'd1, 1'b0, 1'b0); chk("w3_p2", o_integral, 2); chk("w3_fill_p2", o_fill, 0);
    push(8'd1, 1'b0, 1'b0); chk("w3_p3", o_integral, 3); chk("w3_fill_p3", o_fill, 1);
    push(8'd1, 1'b1, 1'b0); chk("w3_l2p1", o_integral, 2);

    // Backpressure mid-line: nothing lost or duplicated.
    cfg_frame_width = 11'd4;
    push(8'd1, 1'b1, 1'b1); chk("bp_p1", o_integral, 1);
    out_ready = 1'b0;
    in_pixel = 8'd2; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_ready_low", in_ready, 0);
      chk("bp_hold", o_integral, 1);
      chk("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_p2", o_integral, 3);
    push(8'd3, 1'b0, 1'b0); chk("bp_p3", o_integral, 6);
    push(8'd4, 1'b0, 1'b0); chk("bp_p4", o_integral, 10); chk("bp_fill", o_fill, 1);
    push(8'd1, 1'b1, 1'b0); chk("bp_l2p1", o_integral, 2);

    // Asynchronous reset after six pixels, then a clean frame.
    push(8'd1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) push(8'd1, 1'b0, 1'b0);
    push(8'd1, 1'b1, 1'b0);
    push(8'd1, 1'b0, 1'b0);
    chk("pre_rst_fill", o_fill, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_integral", o_integral, 0);
    chk("mid_rst_window", o_window, 0);
    chk("mid_rst_fill", o_fill, 0);
    @(posedge clk); #1 reset = 1'b0;
    run_basic("s6");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
